alien_grid: RTL and testbench

- Alien formation controller for the shooter datapath; sits directly downstream of the player bullet block.
- Consumes the bullet position and existence flag each frame, and detects bullet/alien collisions against a grid of live aliens.
- Returns the one-cycle `hit` pulse that the bullet block uses to retire its shot.
- Also marches the formation, keeps score and reports wave-cleared / invaded status to the game FSM and the renderer.

---
 rtl/alien_grid.sv | 227 ++++++++++++++++++++++
 tb/tb_alien_grid.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_grid.sv
// alien_grid: alien formation controller; bullet collision against the live grid, march, score, wave status.
// Latency: bullet inputs to hit pulse is one frame_clk cycle; every output comes straight from a flop.
// Backpressure: none; bullet position is sampled on every MARCH cycle and hit is a fire-and-forget pulse.
//
// Ports: frame_clk, Reset (async, active-low), ready_game, bullet_X/bullet_Y/bullet_on_screen in;
//        hit pulse, alive bitmap (bit = row*COLS+col), grid_X/grid_Y origin, score, wave_cleared, invaded out.
// Optional macro ALIEN_SPEEDUP_EN: move interval shrinks as aliens die (floor of 2 frames per move).

module alien_grid #(
    parameter int ROWS          = 4,
    parameter int COLS          = 8,
    parameter int COL_PITCH_LG2 = 5,
    parameter int ROW_PITCH_LG2 = 4,
    parameter int ALIEN_W       = 16,
    parameter int ALIEN_H       = 8,
    parameter int X_START       = 64,
    parameter int Y_START       = 32,
    parameter int X_MIN         = 16,
    parameter int X_MAX         = 624,
    parameter int Y_LIMIT       = 400,
    parameter int STEP          = 4,
    parameter int DROP          = 8,
    parameter int MOVE_DIV      = 30,
    parameter int POINTS        = 10
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 ready_game,
    input  logic [9:0]           bullet_X,
    input  logic [9:0]           bullet_Y,
    input  logic                 bullet_on_screen,
    output logic                 hit,
    output logic [ROWS*COLS-1:0] alive,
    output logic [9:0]           grid_X,
    output logic [9:0]           grid_Y,
    output logic [15:0]          score,
    output logic                 wave_cleared,
    output logic                 invaded
);
    localparam int NUM   = ROWS * COLS;
    localparam int COL_W = 10 - COL_PITCH_LG2;
    localparam int ROW_W = 10 - ROW_PITCH_LG2;

    typedef enum logic [1:0] {S_IDLE, S_MARCH, S_CLEARED, S_INVADED} state_t;

    state_t         state_q, state_d;
    logic [NUM-1:0] alive_q, alive_d;
    logic [9:0]     grid_x_q, grid_x_d;
    logic [9:0]     grid_y_q, grid_y_d;
    logic           dir_left_q, dir_left_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [15:0]    score_q, score_d;
    logic           hit_q, hit_d;
    logic           wave_cleared_q, wave_cleared_d;
    logic           invaded_q, invaded_d;

    logic [10:0]    dx, dy;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    int             idx;
    logic           in_cell, target_alive, in_box;
    logic [NUM-1:0] kill_mask;
    logic [16:0]    score_sum;
    logic           right_block, left_block, invade_cond, move_now;
    logic [15:0]    div_m1;

`ifdef ALIEN_SPEEDUP_EN
    localparam int KW = $clog2(NUM + 1);
    logic [KW-1:0]  kills_q, kills_d;
    logic [15:0]    kill_half;

    // Interval = max(2, MOVE_DIV - kills/2); expressed as interval-1 for the counter wrap.
    always_comb begin
        kill_half = 16'(kills_q >> 1);
        if (16'(MOVE_DIV) < kill_half + 16'd2) begin
            div_m1 = 16'd1;
        end else begin
            div_m1 = 16'(MOVE_DIV) - kill_half - 16'd1;
        end
    end
`else
    assign div_m1 = 16'(MOVE_DIV - 1);
`endif

    // Collision geometry against the registered (pre-move) origin.
    always_comb begin
        dx  = {1'b0, bullet_X} - {1'b0, grid_x_q};
        dy  = {1'b0, bullet_Y} - {1'b0, grid_y_q};
        col = dx[9:COL_PITCH_LG2];
        row = dy[9:ROW_PITCH_LG2];
        idx = int'(row) * COLS + int'(col);
        // col/row range checks also stop an out-of-range column aliasing into the next row's index.
        in_cell = !dx[10] && !dy[10]
               && (int'(dx[COL_PITCH_LG2-1:0]) < ALIEN_W)
               && (int'(dy[ROW_PITCH_LG2-1:0]) < ALIEN_H)
               && (int'(col) < COLS)
               && (int'(row) < ROWS);
        target_alive = 1'b0;
        kill_mask    = '0;
        for (int i = 0; i < NUM; i++) begin
            if (idx == i) begin
                target_alive = alive_q[i];
                kill_mask[i] = 1'b1;
            end
        end
        in_box = in_cell && bullet_on_screen && target_alive;
    end

    always_comb begin
        right_block = (12'(grid_x_q) + 12'(COLS << COL_PITCH_LG2) + 12'(STEP)) > 12'(X_MAX);
        left_block  = 12'(grid_x_q) < 12'(X_MIN + STEP);
        invade_cond = (12'(grid_y_q) + 12'(ROWS << ROW_PITCH_LG2)) >= 12'(Y_LIMIT);
        // >= rather than == so a shrinking interval can never strand the counter above the wrap point.
        move_now    = cnt_q >= div_m1;
        score_sum   = 17'(score_q) + 17'(POINTS);
    end

    always_comb begin
        state_d    = state_q;
        alive_d    = alive_q;
        grid_x_d   = grid_x_q;
        grid_y_d   = grid_y_q;
        dir_left_d = dir_left_q;
        cnt_d      = cnt_q;
        score_d    = score_q;
        hit_d      = 1'b0;
`ifdef ALIEN_SPEEDUP_EN
        kills_d    = kills_q;
`endif
        if (!ready_game) begin
            // Leaving the game reinitialises the formation but keeps the score.
            state_d    = S_IDLE;
            alive_d    = '1;
            grid_x_d   = 10'(X_START);
            grid_y_d   = 10'(Y_START);
            dir_left_d = 1'b0;
            cnt_d      = '0;
`ifdef ALIEN_SPEEDUP_EN
            kills_d    = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: state_d = S_MARCH;
                S_MARCH: begin
                    // Cleared has priority over invaded.
                    if (alive_q == '0) begin
                        state_d = S_CLEARED;
                    end else if (invade_cond) begin
                        state_d = S_INVADED;
                    end
                    if (in_box) begin
                        hit_d   = 1'b1;
                        alive_d = alive_q & ~kill_mask;
                        score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`ifdef ALIEN_SPEEDUP_EN
                        kills_d = kills_q + KW'(1);
`endif
                    end
                    if (move_now) begin
                        cnt_d = '0;
                        if (!dir_left_q) begin
                            if (right_block) begin
                                grid_y_d   = grid_y_q + 10'(DROP);
                                dir_left_d = 1'b1;
                            end else begin
                                grid_x_d   = grid_x_q + 10'(STEP);
                            end
                        end else begin
                            if (left_block) begin
                                grid_y_d   = grid_y_q + 10'(DROP);
                                dir_left_d = 1'b0;
                            end else begin
                                grid_x_d   = grid_x_q - 10'(STEP);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
        wave_cleared_d = (state_d == S_CLEARED);
        invaded_d      = (state_d == S_INVADED);
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= S_IDLE;
            alive_q        <= '1;
            grid_x_q       <= 10'(X_START);
            grid_y_q       <= 10'(Y_START);
            dir_left_q     <= 1'b0;
            cnt_q          <= '0;
            score_q        <= '0;
            hit_q          <= 1'b0;
            wave_cleared_q <= 1'b0;
            invaded_q      <= 1'b0;
`ifdef ALIEN_SPEEDUP_EN
            kills_q        <= '0;
`endif
        end else begin
            state_q        <= state_d;
            alive_q        <= alive_d;
            grid_x_q       <= grid_x_d;
            grid_y_q       <= grid_y_d;
            dir_left_q     <= dir_left_d;
            cnt_q          <= cnt_d;
            score_q        <= score_d;
            hit_q          <= hit_d;
            wave_cleared_q <= wave_cleared_d;
            invaded_q      <= invaded_d;
`ifdef ALIEN_SPEEDUP_EN
            kills_q        <= kills_d;
`endif
        end
    end

    assign hit          = hit_q;
    assign alive        = alive_q;
    assign grid_X       = grid_x_q;
    assign grid_Y       = grid_y_q;
    assign score        = score_q;
    assign wave_cleared = wave_cleared_q;
    assign invaded      = invaded_q;

endmodule

// File: tb/tb_alien_grid.sv
// tb_alien_grid: checks alien_grid against a frame-level behavioural model every cycle.
// Two instances: default parameters, and a fast-march variant (2 frames per move, narrow
// march limits) used to reach the invasion line quickly. Both see the same inputs; sel picks one.

module tb_alien_grid;
    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        ready_game;
    logic [9:0]  bullet_X, bullet_Y;
    logic        bullet_on_screen;

    logic        a_hit, a_wc, a_inv, f_hit, f_wc, f_inv;
    logic [31:0] a_alive, f_alive;
    logic [9:0]  a_gx, a_gy, f_gx, f_gy;
    logic [15:0] a_score, f_score;

    alien_grid u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .ready_game(ready_game),
        .bullet_X(bullet_X), .bullet_Y(bullet_Y), .bullet_on_screen(bullet_on_screen),
        .hit(a_hit), .alive(a_alive), .grid_X(a_gx), .grid_Y(a_gy),
        .score(a_score), .wave_cleared(a_wc), .invaded(a_inv)
    );

    alien_grid #(.MOVE_DIV(2), .X_MIN(64), .X_MAX(324)) u_fast (
        .frame_clk(frame_clk), .Reset(Reset), .ready_game(ready_game),
        .bullet_X(bullet_X), .bullet_Y(bullet_Y), .bullet_on_screen(bullet_on_screen),
        .hit(f_hit), .alive(f_alive), .grid_X(f_gx), .grid_Y(f_gy),
        .score(f_score), .wave_cleared(f_wc), .invaded(f_inv)
    );

    always #5 frame_clk = ~frame_clk;

    logic        sel;
    logic        d_hit, d_wc, d_inv;
    logic [31:0] d_alive;
    logic [9:0]  d_gx, d_gy;
    logic [15:0] d_score;
    assign d_hit   = sel ? f_hit   : a_hit;
    assign d_wc    = sel ? f_wc    : a_wc;
    assign d_inv   = sel ? f_inv   : a_inv;
    assign d_alive = sel ? f_alive : a_alive;
    assign d_gx    = sel ? f_gx    : a_gx;
    assign d_gy    = sel ? f_gy    : a_gy;
    assign d_score = sel ? f_score : a_score;

    int total, bad;
    bit chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // state: 0 idle, 1 marching, 2 cleared, 3 invaded
    int       m_state, m_gx, m_gy, m_cnt, m_score, m_kills;
    bit       m_left, m_hit;
    bit [31:0] m_alive;

    function automatic int interval(input int base, input int kills);
        int d;
        d = base;
`ifdef ALIEN_SPEEDUP_EN
        d = base - kills / 2;
        if (d < 2) d = 2;
`endif
        return d;
    endfunction

    task automatic model_fresh_grid();
        m_alive = '1; m_gx = 64; m_gy = 32; m_left = 0; m_cnt = 0; m_kills = 0;
    endtask

    task automatic model_frame();
        int xmin, xmax, base, dx, dy, k, nxt, per;
        xmin = sel ? 64 : 16;
        xmax = sel ? 324 : 624;
        base = sel ? 2 : 30;
        m_hit = 0;
        if (!ready_game) begin
            model_fresh_grid();
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            nxt = 1;
            if (m_alive == 0) nxt = 2;
            else if (m_gy + 4 * 16 >= 400) nxt = 3;
            per = interval(base, m_kills);
            dx = int'(bullet_X) - m_gx;
            dy = int'(bullet_Y) - m_gy;
            if (bullet_on_screen && dx >= 0 && dy >= 0 && dx % 32 < 16 && dy % 16 < 8
                && dx / 32 < 8 && dy / 16 < 4) begin
                k = (dy / 16) * 8 + dx / 32;
                if (m_alive[k]) begin
                    m_hit = 1;
                    m_alive[k] = 0;
                    m_kills++;
                    m_score = (m_score + 10 > 65535) ? 65535 : m_score + 10;
                end
            end
            m_cnt++;
            if (m_cnt >= per) begin
                m_cnt = 0;
                if (!m_left) begin
                    if (m_gx + 8 * 32 + 4 > xmax) begin m_gy += 8; m_left = 1; end
                    else m_gx += 4;
                end else begin
                    if (m_gx - 4 < xmin) begin m_gy += 8; m_left = 0; end
                    else m_gx -= 4;
                end
            end
            m_state = nxt;
        end
    endtask

    always @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            model_fresh_grid();
            m_state = 0; m_score = 0; m_hit = 0;
        end else begin
            model_frame();
        end
    end

    always @(negedge frame_clk) begin
        if (chk_en) begin
            check("hit",          32'(d_hit),   32'(m_hit));
            check("alive",        d_alive,      m_alive);
            check("grid_X",       32'(d_gx),    32'(m_gx));
            check("grid_Y",       32'(d_gy),    32'(m_gy));
            check("score",        32'(d_score), 32'(m_score));
            check("wave_cleared", 32'(d_wc),    32'(m_state == 2));
            check("invaded",      32'(d_inv),   32'(m_state == 3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic aim(input int k, input bit on);
        bullet_X = 10'(m_gx + (k % 8) * 32 + $urandom_range(0, 15));
        bullet_Y = 10'(m_gy + (k / 8) * 16 + $urandom_range(0, 7));
        bullet_on_screen = on;
    endtask

    task automatic put(input int x, input int y, input bit on);
        bullet_X = 10'(x); bullet_Y = 10'(y); bullet_on_screen = on;
    endtask

    int order[32];
    int n, j, t;
    logic [19:0] prev;

    initial begin
        total = 0; bad = 0; chk_en = 0; sel = 0;
        Reset = 0; ready_game = 0; put(0, 0, 0);
        repeat (2) @(negedge frame_clk);
        chk_en = 1;
        check("rst_alive", d_alive, 32'hFFFF_FFFF);
        check("rst_grid_X", 32'(d_gx), 32'd64);
        check("rst_grid_Y", 32'(d_gy), 32'd32);
        check("rst_score", 32'(d_score), 32'd0);
        check("rst_flags", {29'd0, d_hit, d_wc, d_inv}, 32'd0);
        Reset = 1;

        // Directed collisions at the origin.
        ready_game = 1;
        @(negedge frame_clk);
        put(84, 35, 1);                       // horizontal gap between columns 0 and 1
        repeat (2) @(negedge frame_clk);
        check("gap_hit", 32'(d_hit), 32'd0);
        check("gap_score", 32'(d_score), 32'd0);
        put(133, 51, 0);                      // alien 10, but no bullet on screen
        repeat (2) @(negedge frame_clk);
        check("offscreen_hit", 32'(d_hit), 32'd0);
        check("offscreen_score", 32'(d_score), 32'd0);
        bullet_on_screen = 1;
        @(negedge frame_clk);
        check("hit10", 32'(d_hit), 32'd1);
        check("kill_bit10", 32'(d_alive[10]), 32'd0);
        check("score10", 32'(d_score), 32'd10);
        @(negedge frame_clk);
        check("no_rehit", 32'(d_hit), 32'd0);
        check("no_rehit_score", 32'(d_score), 32'd10);
        bullet_on_screen = 0;

        // Drop out of the game, then march from the origin.
        ready_game = 0;
        @(negedge frame_clk);
        check("idle_alive", d_alive, 32'hFFFF_FFFF);
        check("idle_score_kept", 32'(d_score), 32'd10);
        ready_game = 1;
        repeat (1 + 76 * 30) @(negedge frame_clk);
        check("march76_X", 32'(d_gx), 32'd368);
        check("march76_Y", 32'(d_gy), 32'd32);
        repeat (30) @(negedge frame_clk);
        check("edge_drop_X", 32'(d_gx), 32'd368);
        check("edge_drop_Y", 32'(d_gy), 32'd40);
        repeat (30) @(negedge frame_clk);
        check("left_step_X", 32'(d_gx), 32'd364);

        // Randomised play: stray bullets, aimed shots, occasional exits from the game.
        for (int c = 0; c < 3000; c++) begin
            ready_game = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 1) == 0) aim(int'($urandom_range(0, 31)), 1'b1);
            else put(m_gx - 8 + int'($urandom_range(0, 280)), m_gy - 8 + int'($urandom_range(0, 80)),
                     $urandom_range(0, 3) != 0);
            @(negedge frame_clk);
        end

        // Asynchronous reset in the middle of a frame, while marching.
        ready_game = 1; bullet_on_screen = 0;
        repeat (40) @(negedge frame_clk);
        @(posedge frame_clk);
        #2 Reset = 0;
        #1;
        check("arst_grid_X", 32'(d_gx), 32'd64);
        check("arst_grid_Y", 32'(d_gy), 32'd32);
        check("arst_alive", d_alive, 32'hFFFF_FFFF);
        check("arst_score", 32'(d_score), 32'd0);
        check("arst_hit", 32'(d_hit), 32'd0);
        @(negedge frame_clk);
        Reset = 1;
        @(negedge frame_clk);

        // Kill the whole wave in a shuffled order.
        for (int i = 0; i < 32; i++) order[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < 32; i++) begin
            aim(order[i], 1'b1);
            @(negedge frame_clk);
        end
        bullet_on_screen = 0;
        check("all_dead", d_alive, 32'd0);
        check("not_yet_cleared", 32'(d_wc), 32'd0);
        @(negedge frame_clk);
        check("wave_cleared", 32'(d_wc), 32'd1);
        check("score320", 32'(d_score), 32'd320);
        ready_game = 0;
        @(negedge frame_clk);
        check("reinit_alive", d_alive, 32'hFFFF_FFFF);
        check("reinit_score", 32'(d_score), 32'd320);
        check("reinit_wc", 32'(d_wc), 32'd0);

        // Move interval after 8 kills.
        ready_game = 1;
        @(negedge frame_clk);
        for (int i = 0; i < 8; i++) begin
            aim(order[i], 1'b1);
            @(negedge frame_clk);
        end
        bullet_on_screen = 0;
        prev = {d_gx, d_gy}; n = 0;
        while ({d_gx, d_gy} == prev && n < 100) begin @(negedge frame_clk); n++; end
        prev = {d_gx, d_gy}; n = 0;
        while ({d_gx, d_gy} == prev && n < 100) begin @(negedge frame_clk); n++; end
`ifdef ALIEN_SPEEDUP_EN
        check("move_interval", 32'(n), 32'd26);
`else
        check("move_interval", 32'(n), 32'd30);
`endif

        // Invasion on the fast-march instance.
        @(negedge frame_clk);
        #2 Reset = 0; sel = 1;
        @(negedge frame_clk);
        Reset = 1; ready_game = 1;
        n = 0;
        while (!d_inv && n < 500) begin @(negedge frame_clk); n++; end
        check("invaded_seen", 32'(d_inv), 32'd1);
        check("invade_Y", 32'(d_gy), 32'd336);
        check("invade_X", 32'(d_gx), 32'd64);
        repeat (10) @(negedge frame_clk);
        check("frozen_Y", 32'(d_gy), 32'd336);
        check("frozen_X", 32'(d_gx), 32'd64);
        check("invaded_held", 32'(d_inv), 32'd1);
        ready_game = 0;
        @(negedge frame_clk);
        check("invade_exit", 32'(d_inv), 32'd0);
        check("invade_exit_Y", 32'(d_gy), 32'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
